// File: rtl/ahb_param_arbiter_pkg.sv
// Shared AHB encodings and arbiter FSM state for the parameterised bus arbiter.
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

package ahb_param_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Beats covered by one burst; undefined-length INCR is capped at max_hold.
  function automatic int unsigned burst_beats(input logic [2:0] hb, input int unsigned max_hold);
    case (hb)
      HB_INCR:            return max_hold;
      HB_WRAP4, HB_INCR4: return 4;
      HB_WRAP8, HB_INCR8: return 8;
      HB_WRAP16, HB_INCR16: return 16;
      default:            return 1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_select.sv
// Grant selection: fixed priority (index 0 first) or rotating priority from ptr.
// Always returns a one-hot grant; DEFAULT_MASTER when nobody requests.
module ahb_arb_select #(
  parameter int NUM_MASTERS    = 4,
  parameter int ARB_MODE       = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] idx,
  output logic                           any
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int PW = MW + 1;

  logic [MW-1:0] start;
  logic [PW-1:0] pos;
  logic          found;

  // Fixed priority is a rotating search that always starts at 0.
  always_comb begin
    start = (ARB_MODE == 1) ? ptr : '0;
    idx   = MW'(DEFAULT_MASTER);
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      pos = PW'(start) + PW'(i);
      if (pos >= PW'(NUM_MASTERS)) pos = pos - PW'(NUM_MASTERS);
      if (!found && req[pos[MW-1:0]]) begin
        found = 1'b1;
        idx   = pos[MW-1:0];
      end
    end
  end

  assign any   = |req;
  assign grant = NUM_MASTERS'(1) << idx;

endmodule

// File: rtl/ahb_param_arbiter.sv
// AHB bus arbiter: fixed/round-robin grant, burst hold with beat counting,
// locked-transfer hold, and Hmaster/Hmastlock address-phase tracking.
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

module ahb_param_arbiter
  import ahb_param_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = `NUM_MASTERS,
  parameter int ARB_MODE       = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                           Hclk,
  input  logic                           Hresetn,
  input  logic [NUM_MASTERS-1:0]         Hreq,
  input  logic [NUM_MASTERS-1:0]         Hlock,
  input  logic                           Hready,
  input  logic [1:0]                     Htrans,
  input  logic [2:0]                     Hburst,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
  output logic                           Hmastlock
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2((MAX_HOLD > 16 ? MAX_HOLD : 16) + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [MW-1:0]          master_q;
  logic                   mastlock_q;

  logic [NUM_MASTERS-1:0] sel_grant;
  logic [MW-1:0]          sel_idx;
  logic                   sel_any;
  logic [MW-1:0]          owner_idx;
  logic                   owner_lock;
  logic                   rearb;

  ahb_arb_select #(
    .NUM_MASTERS   (NUM_MASTERS),
    .ARB_MODE      (ARB_MODE),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_sel (
    .req  (Hreq),
    .ptr  (ptr_q),
    .grant(sel_grant),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) owner_idx = MW'(i);
  end

  assign owner_lock = |(Hlock & grant_q);

  // cnt is loaded with the full burst length on the NONSEQ beat, so a SEQ
  // beat seen with cnt==2 is the final beat of the burst.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rearb   = 1'b0;
    if (owner_lock) begin
      state_d = ST_LOCKED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ARB:
          if (Htrans == HT_NONSEQ && Hburst != HB_SINGLE) begin
            state_d = ST_BURST;
            cnt_d   = CW'(burst_beats(Hburst, MAX_HOLD));
          end else begin
            rearb = 1'b1;
          end
        ST_BURST:
          if (Htrans == HT_IDLE || Htrans == HT_NONSEQ) begin
            rearb = 1'b1;
          end else if (Htrans == HT_SEQ) begin
            if (cnt_q <= CW'(2)) rearb = 1'b1;
            else                 cnt_d = cnt_q - 1'b1;
          end
        // Lock just dropped: keep the grant for one more address phase.
        ST_LOCKED: state_d = ST_ARB;
        default:   state_d = ST_ARB;
      endcase
    end
    if (rearb) begin
      state_d = ST_ARB;
      cnt_d   = '0;
      grant_d = sel_grant;
      if (sel_any)
        ptr_d = (sel_idx == MW'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q    <= ST_ARB;
      grant_q    <= DEF_GRANT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      master_q   <= MW'(DEFAULT_MASTER);
      mastlock_q <= 1'b0;
    end else if (Hready) begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      master_q   <= owner_idx;
      mastlock_q <= owner_lock;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = master_q;
  assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Bench for ahb_param_arbiter: fixed and round-robin instances share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_ahb_param_arbiter;
  import ahb_param_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXH = 16;

  logic       Hclk = 1'b0;
  logic       Hresetn;
  logic [3:0] Hreq, Hlock;
  logic       Hready;
  logic [1:0] Htrans;
  logic [2:0] Hburst;

  logic [3:0] rr_grant, fx_grant;
  logic [1:0] rr_master, fx_master;
  logic       rr_mlock, fx_mlock;

  int tests = 0;
  int fails = 0;

  // Reference model, index 0 = fixed priority, 1 = round robin.
  int m_owner[2], m_mast[2], m_rem[2], m_ptr[2];
  bit m_mlock[2], m_locked[2];

  logic [1:0] tr39 [0:6] = '{HT_NONSEQ, HT_BUSY, HT_SEQ, HT_SEQ, HT_BUSY, HT_SEQ, HT_SEQ};
  logic       rd39 [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 Hclk = ~Hclk;

  ahb_param_arbiter dut_rr (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(rr_grant), .Hmaster(rr_master),
    .Hmastlock(rr_mlock)
  );

  ahb_param_arbiter #(.ARB_MODE(0)) dut_fx (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
    .Htrans(Htrans), .Hburst(Hburst), .Hgrant(fx_grant), .Hmaster(fx_master),
    .Hmastlock(fx_mlock)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int blen(input logic [2:0] hb);
    case (hb)
      3'd1:       return MAXH;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = DEF; m_mast[m] = DEF; m_mlock[m] = 0;
      m_rem[m] = 0; m_locked[m] = 0; m_ptr[m] = 0;
    end
  endtask

  // Advances the model by one clock edge using the inputs applied before it.
  task automatic model_step();
    bit lk, rearb;
    int w, c;
    if (!Hresetn) begin
      model_reset();
      return;
    end
    if (!Hready) return;
    for (int m = 0; m < 2; m++) begin
      lk    = Hlock[m_owner[m]];
      rearb = 0;
      if (lk) begin
        m_locked[m] = 1; m_rem[m] = 0;
      end else if (m_locked[m]) begin
        m_locked[m] = 0;
      end else if (m_rem[m] > 0) begin
        if (Htrans == HT_IDLE || Htrans == HT_NONSEQ) begin
          m_rem[m] = 0; rearb = 1;
        end else if (Htrans == HT_SEQ) begin
          m_rem[m]--;
          rearb = (m_rem[m] == 0);
        end
      end else if (Htrans == HT_NONSEQ && Hburst != HB_SINGLE) begin
        m_rem[m] = blen(Hburst) - 1;
      end else begin
        rearb = 1;
      end
      m_mast[m]  = m_owner[m];
      m_mlock[m] = lk;
      if (rearb) begin
        if (Hreq == 4'b0000) m_owner[m] = DEF;
        else begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            c = ((m == 1 ? m_ptr[m] : 0) + k) % N;
            if (w < 0 && Hreq[c]) w = c;
          end
          m_owner[m] = w;
          m_ptr[m]   = (w + 1) % N;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] g, eg;
    logic [1:0] hm;
    logic       ml;
    for (int m = 0; m < 2; m++) begin
      g  = (m == 1) ? rr_grant  : fx_grant;
      hm = (m == 1) ? rr_master : fx_master;
      ml = (m == 1) ? rr_mlock  : fx_mlock;
      eg = '0;
      eg[m_owner[m]] = 1'b1;
      chk($sformatf("grant_m%0d", m),  32'(g),  32'(eg));
      chk($sformatf("master_m%0d", m), 32'(hm), 32'(m_mast[m]));
      chk($sformatf("mlock_m%0d", m),  32'(ml), 32'(m_mlock[m]));
      chk($sformatf("onehot_m%0d", m), 32'($onehot(g)), 32'd1);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Hclk);
    #1;
    check_model();
  endtask

  initial begin
    int r;
    Hresetn = 1'b0; Hreq = '0; Hlock = '0; Hready = 1'b1;
    Htrans = HT_IDLE; Hburst = HB_SINGLE;
    model_reset();
    cycle(); cycle();
    chk("rst_grant", 32'(rr_grant), 32'h1);
    chk("rst_master", 32'(rr_master), 32'h0);
    chk("rst_mlock", 32'(fx_mlock), 32'h0);
    Hresetn = 1'b1;

    // Fixed priority picks lowest index; Hmaster lags by a cycle.
    Hreq = 4'b1010; cycle();
    chk("fx_1010_grant", 32'(fx_grant), 32'h2);
    cycle();
    chk("fx_1010_master", 32'(fx_master), 32'h1);

    // Round robin rotation from a fresh pointer.
    Hresetn = 1'b0; cycle(); Hresetn = 1'b1;
    Hreq = 4'b1111; Htrans = HT_NONSEQ; Hburst = HB_SINGLE;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("rr_rot%0d", i), 32'(rr_grant), 32'(4'b0001 << i));
    end

    // INCR4 from master 2 with BUSY and wait states inserted.
    Hreq = 4'b0100; Htrans = HT_IDLE; cycle();
    Hreq = 4'b1111; Hburst = HB_INCR4;
    for (int i = 0; i < 7; i++) begin
      Htrans = tr39[i]; Hready = rd39[i];
      cycle();
      if (i < 6) begin
        chk("incr4_hold_rr", 32'(rr_grant), 32'h4);
        chk("incr4_hold_fx", 32'(fx_grant), 32'h4);
      end
    end
    chk("incr4_end_rr", 32'(rr_grant), 32'h8);
    chk("incr4_end_fx", 32'(fx_grant), 32'h1);
    Hready = 1'b1;

    // Master 1 locked during INCR8 with everyone requesting.
    Hreq = 4'b0010; Htrans = HT_IDLE; Hburst = HB_SINGLE; cycle();
    Hreq = 4'b1111; Hlock = 4'b0010; Hburst = HB_INCR8;
    for (int i = 0; i < 6; i++) begin
      Htrans = (i == 0) ? HT_NONSEQ : HT_SEQ;
      cycle();
      chk("lock_grant", 32'(rr_grant), 32'h2);
      chk("lock_mlock", 32'(rr_mlock), 32'h1);
    end
    Hlock = 4'b0000; Htrans = HT_IDLE; cycle();
    chk("unlock_hold", 32'(rr_grant), 32'h2);
    chk("unlock_mlock", 32'(rr_mlock), 32'h0);
    cycle();
    chk("unlock_rearb_rr", 32'(rr_grant), 32'h4);
    chk("unlock_rearb_fx", 32'(fx_grant), 32'h1);

    // Master 0 INCR of 20 beats, capped at MAX_HOLD.
    Hreq = 4'b0001; Htrans = HT_IDLE; cycle();
    Hreq = 4'b0011; Hburst = HB_INCR;
    for (int i = 0; i < 20; i++) begin
      Htrans = (i == 0) ? HT_NONSEQ : HT_SEQ;
      cycle();
      if (i < 15) chk("incr_hold", 32'(rr_grant), 32'h1);
      if (i == 15) begin
        chk("incr_cap_rr", 32'(rr_grant), 32'h2);
        chk("incr_cap_fx", 32'(fx_grant), 32'h1);
      end
    end

    // Asynchronous reset mid WRAP8 (owner locked so Hmastlock is high first).
    Hreq = 4'b1111; Hburst = HB_WRAP8; Htrans = HT_NONSEQ; cycle();
    Htrans = HT_SEQ; cycle();
    Hlock = 4'b1111; cycle();
    chk("pre_rst_mlock", 32'(rr_mlock), 32'h1);
    #2 Hresetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_grant_rr", 32'(rr_grant), 32'h1);
    chk("async_rst_grant_fx", 32'(fx_grant), 32'h1);
    chk("async_rst_mlock", 32'(rr_mlock), 32'h0);
    check_model();
    Hlock = 4'b0000; cycle();
    Hresetn = 1'b1;
    Hreq = 4'b0100; Htrans = HT_IDLE; cycle();
    chk("resume_rr", 32'(rr_grant), 32'h4);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      Hreq   = 4'($urandom);
      Hlock  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      Hready = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      Htrans = (r < 2) ? HT_IDLE : (r == 2) ? HT_BUSY : (r < 5) ? HT_NONSEQ : HT_SEQ;
      Hburst = 3'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_param_arbiter.md
AHB_PARAM_ARBITER -- requirements
Module: ahb_param_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default `NUM_MASTERS (4), number of requesting masters, 2..16.
REQ-002 SHALL have parameter ARB_MODE, default 1, 0 = fixed priority (index 0 highest), 1 = round robin.
REQ-003 SHALL have parameter DEFAULT_MASTER, default 0, master granted when no request is pending.
REQ-004 SHALL have parameter MAX_HOLD, default 16, beat limit for an undefined-length INCR burst.
REQ-005 SHALL have port Hclk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port Hresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Hreq, input, NUM_MASTERS, per-master bus request.
REQ-008 SHALL have port Hlock, input, NUM_MASTERS, per-master locked-transfer request.
REQ-009 SHALL have port Hready, input, 1, bus transfer complete.
REQ-010 SHALL have port Htrans, input, 2, current owner's transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-011 SHALL have port Hburst, input, 3, current owner's burst type.
REQ-012 SHALL have port Hgrant, output, NUM_MASTERS, one-hot grant.
REQ-013 SHALL have port Hmaster, output, $clog2(NUM_MASTERS), index of the address-phase owner.
REQ-014 SHALL have port Hmastlock, output, 1, current address-phase transfer is locked.

Function
REQ-015 SHALL keep exactly one bit of Hgrant set at all times out of reset.
REQ-016 SHALL implement FSM states ARB, BURST, LOCKED.
REQ-017 SHALL, in ARB with Hready=1, select a winner from Hreq; Hgrant updates on that edge, visible the next cycle.
REQ-018 SHALL, in ARB_MODE 0, grant the lowest-index requester.
REQ-019 SHALL, in ARB_MODE 1, search from a rotating pointer and set the pointer to winner+1 (mod NUM_MASTERS) on each new grant.
REQ-020 SHALL grant DEFAULT_MASTER when Hreq is all-zero; the RR pointer is unchanged in that case.
REQ-021 SHALL count a beat on each Hclk edge with Hready=1 and Htrans in NONSEQ or SEQ; BUSY and IDLE are not counted.
REQ-022 SHALL, on a NONSEQ beat with Hburst != SINGLE, load the beat counter (INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=MAX_HOLD) and enter BURST.
REQ-023 SHALL, in BURST, hold Hgrant until the counter reaches the last beat, then re-arbitrate on that edge and return to ARB.
REQ-024 SHALL terminate BURST early and return to ARB when Htrans=IDLE or NONSEQ with Hready=1 before the counter expires.
REQ-025 SHALL, for an INCR burst reaching MAX_HOLD beats, force re-arbitration even if the owner still requests.
REQ-026 SHALL, when the granted master asserts Hlock with Hready=1, enter LOCKED and hold Hgrant regardless of burst count or other requests.
REQ-027 SHALL leave LOCKED on the first Hready=1 edge with the owner's Hlock=0, passing through one further address phase before re-arbitration.
REQ-028 SHALL freeze all state, counters and grants while Hready=0.
REQ-029 SHALL update Hmaster to the index of Hgrant on every Hready=1 edge (one-cycle lag behind Hgrant).
REQ-030 SHALL register Hmastlock from the granted master's Hlock on every Hready=1 edge.
REQ-031 SHALL ignore Hreq changes from non-owners while in BURST or LOCKED.

Reset
REQ-032 SHALL, with Hresetn=0, force Hgrant to one-hot DEFAULT_MASTER, Hmaster=DEFAULT_MASTER, Hmastlock=0, state ARB, beat counter 0, RR pointer 0.
REQ-033 SHALL abandon any BURST or LOCKED state immediately on reset assertion mid-transfer.
REQ-034 SHALL resume normal arbitration on the first Hready=1 edge after Hresetn deasserts.

Structure
REQ-035 SHALL import Htrans and Hburst encodings and the FSM state enum from the shared AHB package.
REQ-036 SHALL place the grant-selection logic (fixed or rotating priority, one-hot out) in sub-module ahb_arb_select.

Verification
REQ-037 Fixed mode, Hreq=4'b1010 -> Hgrant=4'b0010 next cycle, Hmaster=1 one cycle later.
REQ-038 RR mode, Hreq=4'b1111 held for 4 SINGLE beats -> grants 0001,0010,0100,1000 in order.
REQ-039 Master 2 INCR4 with Hreq=4'b1111 -> Hgrant stays 4'b0100 for 4 counted beats, including 2 BUSY and 1 Hready=0 cycle inserted mid-burst.
REQ-040 Master 1 Hlock=1 for 6 cycles during INCR8 with all requesting -> Hgrant=4'b0010 and Hmastlock=1 throughout; release one address phase after Hlock drops.
REQ-041 Master 0 INCR of 20 beats with MAX_HOLD=16 -> forced re-arbitration after beat 16.
REQ-042 Hresetn pulsed low mid-WRAP8 -> Hgrant=one-hot DEFAULT_MASTER, Hmastlock=0 asynchronously, before the next edge.
